// File: rtl/map_hub_seq.sv
// map_hub_seq: registered mapper output selector with glitch-free switchover.
// A selection change drives SAFE_VAL, drains for HOLD_CYC cycles, then
// commits on the first quiet bus cycle. lock freezes the drain and commit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | committed channel drives map_out; watching for a new target
// DRAIN  | SAFE_VAL on map_out; drain counter running down to 1
// WAIT_Q | SAFE_VAL on map_out; waiting for quiet to commit
module map_hub_seq #(
  parameter int N_CH     = 8,
  parameter int W_OUT    = 64,
  parameter int W_IDX    = 8,
  parameter int HOLD_CYC = 4,
  parameter logic [W_OUT-1:0] SAFE_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W_IDX-1:0]          map_idx,
  input  logic [N_CH*W_IDX-1:0]     idx_tab,
  input  logic [N_CH*W_OUT-1:0]     ch_out,
  input  logic                      quiet,
  input  logic                      lock,
  output logic [W_OUT-1:0]          map_out,
  output logic [$clog2(N_CH)-1:0]   cur_ch,
  output logic                      hit,
  output logic                      busy,
  output logic                      sw_done
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(HOLD_CYC);

  typedef enum logic [1:0] {RUN, DRAIN, WAIT_Q} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   tgt_q;
  logic [CH_W-1:0]   target;
  logic              hit_c;
  logic [W_OUT-1:0]  cur_dat;
  logic [W_OUT-1:0]  tgt_dat;

  // Lookup: scan downwards so the lowest matching channel wins; entry 0 is never compared.
  always_comb begin
    target = '0;
    for (int k = N_CH - 1; k >= 1; k--) begin
      if (idx_tab[k*W_IDX +: W_IDX] == map_idx) target = CH_W'(k);
    end
  end

  assign hit_c   = (target != '0);
  assign cur_dat = ch_out[cur_ch*W_OUT +: W_OUT];
  assign tgt_dat = ch_out[tgt_q*W_OUT +: W_OUT];
  assign busy    = (state != RUN);

  // Switchover FSM; map_out is SAFE_VAL unless the next state is RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      tgt_q   <= '0;
      cur_ch  <= '0;
      map_out <= SAFE_VAL;
      hit     <= 1'b0;
      sw_done <= 1'b0;
    end else begin
      hit     <= hit_c;
      sw_done <= 1'b0;
      map_out <= SAFE_VAL;
      case (state)
        RUN: begin
          if (target != cur_ch && !lock) begin
            tgt_q <= target;
            if (HOLD_CYC == 0) begin
              state <= WAIT_Q;
            end else begin
              state <= DRAIN;
              cnt   <= CNT_LD;
            end
          end else begin
            map_out <= cur_dat;
          end
        end
        DRAIN: begin
          if (target == cur_ch) begin
            state   <= RUN;
            cnt     <= '0;
            map_out <= cur_dat;
          end else if (target != tgt_q) begin
            tgt_q <= target;
            cnt   <= CNT_LD;
          end else if (!lock) begin
            if (cnt == CNT_W'(1)) state <= WAIT_Q;
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT_Q: begin
          if (target == cur_ch) begin
            state   <= RUN;
            map_out <= cur_dat;
          end else if (target != tgt_q) begin
            tgt_q <= target;
            // With no drain interval a retarget simply keeps waiting for quiet.
            if (HOLD_CYC != 0) begin
              state <= DRAIN;
              cnt   <= CNT_LD;
            end
          end else if (quiet && !lock) begin
            state   <= RUN;
            cur_ch  <= tgt_q;
            map_out <= tgt_dat;
            sw_done <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/map_hub_seq.md
# map_hub_seq

Parametrised, registered successor to the combinational mapper hub. It selects one of `N_CH` mapper output buses by matching `map_idx` against a per-channel index table. On a selection change it performs a glitch-free switchover: a safe idle output is driven, a programmable drain interval elapses, and the switch commits only on a quiet bus cycle. It sits between the mapper instances and the cartridge bus drivers, and can be frozen during save-state operations.

## Interface
Parameters:
- `N_CH`, 8: number of mapper channels; channel 0 is the nominal/default mapper.
- `W_OUT`, 64: width of one mapper output bus.
- `W_IDX`, 8: width of a mapper index.
- `HOLD_CYC`, 4: drain cycles with safe output before commit (0 allowed).
- `SAFE_VAL`, all zeros: output value during switchover and reset.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: asynchronous reset, active low.
- `map_idx` in `W_IDX`: requested mapper index.
- `idx_tab` in `N_CH*W_IDX`: index of channel k at bits [k*W_IDX +: W_IDX]; entry 0 is ignored.
- `ch_out` in `N_CH*W_OUT`: output bus of channel k at [k*W_OUT +: W_OUT].
- `quiet` in 1: bus idle qualifier (M2 low, no access in flight).
- `lock` in 1: freeze selection (save-state in progress).
- `map_out` out `W_OUT`: registered selected output.
- `cur_ch` out `$clog2(N_CH)`: committed channel.
- `hit` out 1: registered; 1 when `map_idx` matched a table entry k≥1.
- `busy` out 1: 1 while state ≠ RUN.
- `sw_done` out 1: one-cycle pulse on commit.

## Operation
- Lookup (combinational): target = lowest k in 1..N_CH-1 with `idx_tab[k]==map_idx`; if there is no match, target = 0. Duplicate entries resolve to the lowest k.
- States:
  - RUN: if `target != cur_ch` and `!lock`, go to DRAIN and load cnt=`HOLD_CYC`. When `HOLD_CYC==0`, go directly to WAIT_Q.
  - DRAIN: cnt decrements each cycle; at cnt==1, go to WAIT_Q.
  - WAIT_Q: when `quiet`=1, go to RUN, set `cur_ch`<=latched target, and pulse `sw_done`.
- Target latch: the target is latched on entry to DRAIN or WAIT_Q, and re-latched each cycle in DRAIN/WAIT_Q. If the target changes to a new value ≠ `cur_ch`, cnt reloads to `HOLD_CYC` and the state becomes DRAIN, restarting the drain.
- Abort: if the target returns to `cur_ch` while in DRAIN or WAIT_Q, go to RUN next cycle without `sw_done`; `cur_ch` is unchanged.
- `lock`=1:
  - In RUN, no transition.
  - In DRAIN, cnt holds.
  - In WAIT_Q, commit is inhibited.
  - `map_out` keeps following its source rule.
- Output register source: next_state==RUN ? `ch_out[next_cur_ch]` : `SAFE_VAL`. As a result, no old-channel data leaks after the decision edge, and new-channel data appears at the commit edge.
- Reset values: state RUN, `cur_ch`=0, `map_out`=`SAFE_VAL`, `hit`=0, `busy`=0, `sw_done`=0, cnt=0. The first post-reset edge in RUN loads `ch_out[0]` and evaluates the target normally.

## Timing
- RUN steady state: 1-cycle latency from `ch_out` to `map_out`.
- Switch with `quiet` held high: the decision edge E0 puts `SAFE_VAL` on `map_out`.
  - `busy`=1 from E0 to E0+`HOLD_CYC`.
  - Commit at edge E0+`HOLD_CYC`+1: `map_out`=`ch_out[new]` and `sw_done`=1 for that cycle.
  - `HOLD_CYC`=0: commit at E0+1.
- `quiet` low in WAIT_Q: stalls indefinitely, with `SAFE_VAL` held.
- `hit`: registered from the lookup each cycle, independent of state.
- Reset assertion mid-switch: asynchronous return to the reset values; no `sw_done`.
- `cnt` width: `$clog2(HOLD_CYC+1)`, minimum 1. It never underflows.

## Test plan
- Reset, then steady selection: N_CH=4, idx_tab={x,11,13,34}, map_idx=13, HOLD_CYC=4, quiet=1.
  - Post-reset `map_out`=0.
  - Commit to ch2 at E0+5, `sw_done` pulse once.
  - `map_out` then tracks `ch_out[2]` with 1-cycle lag.
- No-match default: while on ch2, map_idx=99.
  - `hit`=0.
  - Switch to ch0 after 4 drain cycles plus commit.
  - `map_out`=`ch_out[0]`.
- Retarget and abort: from ch1, map_idx=34, then 13 at drain cycle 2.
  - cnt reloads, commit to ch2 at 5 cycles after the retarget.
  - Repeat with the retarget set back to 11: return to RUN next cycle, no `sw_done`, `cur_ch`=1.
- Quiet gating: enter WAIT_Q with quiet=0 for 10 cycles.
  - `map_out`=`SAFE_VAL`, `busy`=1 throughout.
  - quiet=1: commit on that edge.
- Lock: lock=1 in RUN with map_idx changed gives no switch. lock=1 mid-DRAIN freezes cnt. Release resumes the remaining count.
- Duplicates and async reset: idx_tab={x,13,13,34}, map_idx=13 selects ch1. Asserting rst_n=0 mid-DRAIN forces `map_out`=0 and `cur_ch`=0 immediately, without waiting for `clk`.
